// File: rtl/unary_pkg.sv
// Shared types for the unary accumulator family: FSM state encoding and the
// popcount width helper used to size the lane adder.
package unary_pkg;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    EMIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Bits needed to hold a count of 0..n set lanes.
  function automatic int popw(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/unary_popcount.sv
// Combinational popcount of N_IN unary lanes.
module unary_popcount
  import unary_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int PW   = popw(N_IN)
) (
  input  logic [N_IN-1:0] din,
  output logic [PW-1:0]   pop
);

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_IN; i++) pop = pop + PW'(din[i]);
  end

endmodule

// File: rtl/unary_accum_n.sv
// Unary accumulator/emitter: sums ones from N_IN lanes in write mode, then
// replays the total as a serial unary pulse train with a done strobe.
module unary_accum_n
  import unary_pkg::*;
#(
  parameter int N_IN     = 2,
  parameter int CNT_W    = 3,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             read_or_write,
  input  logic [N_IN-1:0]  din,
  output logic             dout,
  output logic             C,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  localparam int PW = popw(N_IN);
  // One spare bit above the wider operand so the overflow is never lost.
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [SW-1:0] CMAX = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [PW-1:0]    pop;
  logic [SW-1:0]    sum;
  logic             ovf;
  logic [CNT_W-1:0] acc_next;
  state_t           state;

  unary_popcount #(.N_IN(N_IN), .PW(PW)) u_pop (
    .din (din),
    .pop (pop)
  );

  assign sum      = SW'(count) + SW'(pop);
  assign ovf      = sum > CMAX;
  assign acc_next = (ovf && SATURATE) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      count <= '0;
      C     <= 1'b0;
      dout  <= 1'b0;
      done  <= 1'b0;
    end else if (!en) begin
      // Frozen: state and count hold, outputs go quiet until en returns.
      dout <= 1'b0;
      done <= 1'b0;
    end else if (clr) begin
      state <= ACC;
      count <= '0;
      C     <= 1'b0;
      dout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      dout <= 1'b0;
      done <= 1'b0;
      case (state)
        ACC: begin
          // Mode switch wins over the add: din of the switch cycle is dropped.
          if (read_or_write) state <= EMIT;
          else begin
            count <= acc_next;
            if (ovf) C <= 1'b1;
          end
        end
        EMIT: begin
          if (!read_or_write) state <= ACC;
          else if (count != '0) begin
            dout  <= 1'b1;
            count <= count - CNT_W'(1);
          end else begin
            done  <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: if (!read_or_write) state <= ACC;
        default: state <= ACC;
      endcase
    end
  end

endmodule
